branch_resolve_unit: RTL

Parametrised, pipelined branch/jump resolution unit for the execute stage. It accepts one control-flow instruction per cycle with its operands, PC and front-end prediction. It evaluates all RV32I branch conditions plus JAL/JALR, computes the actual target, and flags mispredictions with a redirect PC. The block has a one-entry registered output with valid/ready backpressure, flush support, and saturating performance counters.

---
 rtl/branch_resolve_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for the execute stage.
// Resolves RV32I BRANCH/JAL/JALR outcome and target, compares them against
// the front-end prediction, and holds one registered result behind a
// valid/ready handshake. Saturating counters track resolved control-flow
// instructions and mispredictions.
`timescale 1ns/1ps

module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_target,
  input  logic [TAG_W-1:0] i_in_tag,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_out_is_cf,
  output logic             o_out_taken,
  output logic [XLEN-1:0]  o_out_target,
  output logic             o_out_mispredict,
  output logic [XLEN-1:0]  o_out_redirect_pc,
  output logic             o_out_illegal,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_mispred_count
);

  localparam logic [6:0]       OP_BRANCH = 7'b1100011;
  localparam logic [6:0]       OP_JAL    = 7'b1101111;
  localparam logic [6:0]       OP_JALR   = 7'b1100111;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Decode fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_is_cf;

  // Immediates, sign-extended to XLEN
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_i;

  // Candidate targets
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_jal_target;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_target;

  // Comparisons
  logic            w_eq;
  logic            w_lt_s;
  logic            w_lt_u;

  // Resolved result
  logic            w_cond;
  logic            w_illegal;
  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_redirect;
  logic            w_mispredict;

  // Handshake
  logic            w_accept;
  logic            w_handshake;

  // Output registers
  logic             r_out_valid;
  logic [TAG_W-1:0] r_tag;
  logic             r_is_cf;
  logic             r_taken;
  logic [XLEN-1:0]  r_target;
  logic             r_mispredict;
  logic [XLEN-1:0]  r_redirect;
  logic             r_illegal;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mispred_count;

  assign w_opcode  = i_instr[6:0];
  assign w_funct3  = i_instr[14:12];
  assign w_is_br   = (w_opcode == OP_BRANCH);
  assign w_is_jal  = (w_opcode == OP_JAL);
  assign w_is_jalr = (w_opcode == OP_JALR);
  assign w_is_cf   = w_is_br | w_is_jal | w_is_jalr;

  assign w_imm_b = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_j = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_i = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};

  assign w_pc_plus4    = i_pc + XLEN'(4);
  assign w_br_target   = i_pc + w_imm_b;
  assign w_jal_target  = i_pc + w_imm_j;
  assign w_jalr_sum    = i_rs1 + w_imm_i;
  assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};

  assign w_eq   = (i_rs1 == i_rs2);
  assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
  assign w_lt_u = (i_rs1 < i_rs2);

  // Branch condition by funct3; 010/011 are reserved and never taken
  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (w_funct3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt_s;
      3'b101:  w_cond = ~w_lt_s;
      3'b110:  w_cond = w_lt_u;
      3'b111:  w_cond = ~w_lt_u;
      default: w_illegal = w_is_br;
    endcase
  end

  // Select outcome and target by instruction class
  always_comb begin
    w_taken  = 1'b0;
    w_target = '0;
    if (w_is_br) begin
      w_taken  = w_cond;
      w_target = w_br_target;
    end else if (w_is_jal) begin
      w_taken  = 1'b1;
      w_target = w_jal_target;
    end else if (w_is_jalr) begin
      w_taken  = 1'b1;
      w_target = w_jalr_target;
    end
  end

  assign w_redirect   = w_taken ? w_target : w_pc_plus4;
  assign w_mispredict = (w_taken != i_pred_taken) |
                        (w_taken & i_pred_taken & (w_target != i_pred_target));

  assign o_in_ready  = ~r_out_valid | i_out_ready;
  assign w_accept    = i_in_valid & o_in_ready & ~i_flush;
  assign w_handshake = r_out_valid & i_out_ready;

  // Output slot: flush kills, accept loads (replacing a consumed result), handshake drains
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid  <= 1'b0;
      r_tag        <= '0;
      r_is_cf      <= 1'b0;
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_mispredict <= 1'b0;
      r_redirect   <= '0;
      r_illegal    <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_tag        <= i_in_tag;
      r_is_cf      <= w_is_cf;
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_mispredict <= w_mispredict;
      r_redirect   <= w_redirect;
      r_illegal    <= w_illegal;
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end
  end

  // Saturating counters; a handshake in a flush cycle still counts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (w_handshake) begin
      if (r_is_cf && (r_br_count != CNT_MAX))
        r_br_count <= r_br_count + 1'b1;
      if (r_mispredict && (r_mispred_count != CNT_MAX))
        r_mispred_count <= r_mispred_count + 1'b1;
    end
  end

  assign o_out_valid       = r_out_valid;
  assign o_out_tag         = r_tag;
  assign o_out_is_cf       = r_is_cf;
  assign o_out_taken       = r_taken;
  assign o_out_target      = r_target;
  assign o_out_mispredict  = r_mispredict;
  assign o_out_redirect_pc = r_redirect;
  assign o_out_illegal     = r_illegal;
  assign o_br_count        = r_br_count;
  assign o_mispred_count   = r_mispred_count;

endmodule
